// File: rtl/conv_seq_ctrl_if.sv
// Handshake and status bundle between the convolution sequencer and its datapath.
// The sequencer uses the slave view; the stimulus side drives through the master view.
interface conv_seq_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int OUT_W  = 13
);
    logic              i_in_valid;
    logic              i_barcode_found;
    logic              i_dec_done;
    logic              i_dec_ok;
    logic [OUT_W-1:0]  i_out_num;
    logic              i_conv_valid;
    logic              i_out_ready;

    logic              o_in_ready;
    logic [ADDR_W-1:0] o_img_addr;
    logic [ADDR_W-1:0] o_wgt_addr;
    logic [8:0]        o_state_onehot;
    logic              o_cfg_valid;
    logic [OUT_W-1:0]  o_out_cnt;
    logic              o_exe_finish;
    logic              o_error;

    modport slave (
        input  i_in_valid, i_barcode_found, i_dec_done, i_dec_ok, i_out_num,
               i_conv_valid, i_out_ready,
        output o_in_ready, o_img_addr, o_wgt_addr, o_state_onehot, o_cfg_valid,
               o_out_cnt, o_exe_finish, o_error
    );

    modport master (
        output i_in_valid, i_barcode_found, i_dec_done, i_dec_ok, i_out_num,
               i_conv_valid, i_out_ready,
        input  o_in_ready, o_img_addr, o_wgt_addr, o_state_onehot, o_cfg_valid,
               o_out_cnt, o_exe_finish, o_error
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Top-level sequencer for the barcode-configured convolution engine: image load,
// barcode search with timeout, decode, config, weight load, convolution, terminal states.
module conv_seq_ctrl #(
    parameter int IMG_DEPTH    = 4096,
    parameter int WGT_DEPTH    = 9,
    parameter int SEARCH_LIMIT = 4096,
    parameter int ADDR_W       = 12,
    parameter int OUT_W        = 13
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    conv_seq_ctrl_if.slave  bus
);

    localparam int SRCH_W = (SEARCH_LIMIT > 1) ? $clog2(SEARCH_LIMIT) : 1;

    localparam logic [ADDR_W-1:0] IMG_LAST    = ADDR_W'(IMG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] WGT_LAST    = ADDR_W'(WGT_DEPTH - 1);
    localparam logic [SRCH_W-1:0] SEARCH_LAST = SRCH_W'(SEARCH_LIMIT - 1);

    // One-hot encoding so the state register drives o_state_onehot directly.
    typedef enum logic [8:0] {
        S_IDLE     = 9'h001,
        S_LOAD_IMG = 9'h002,
        S_FIND     = 9'h004,
        S_DECODE   = 9'h008,
        S_OUT_CFG  = 9'h010,
        S_LOAD_WGT = 9'h020,
        S_CONV     = 9'h040,
        S_DONE     = 9'h080,
        S_ERROR    = 9'h100
    } state_e;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic [ADDR_W-1:0] wgt_addr_q, wgt_addr_d;
    logic [SRCH_W-1:0] timer_q,    timer_d;
    logic [OUT_W-1:0]  out_num_q,  out_num_d;
    logic [OUT_W-1:0]  out_cnt_q,  out_cnt_d;

    logic              conv_hs;

    assign conv_hs = bus.i_conv_valid && bus.i_out_ready;

    // NOTE: every variable gets its default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        img_addr_d = img_addr_q;
        wgt_addr_d = wgt_addr_q;
        timer_d    = '0;
        out_num_d  = out_num_q;
        out_cnt_d  = out_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_LOAD_IMG;
            end

            S_LOAD_IMG: begin
                if (bus.i_in_valid) begin
                    if (img_addr_q == IMG_LAST) begin
                        img_addr_d = '0;
                        state_d    = S_FIND;
                    end else begin
                        img_addr_d = img_addr_q + ADDR_W'(1);
                    end
                end
            end

            // The timer is held at zero outside FIND, so each entry starts fresh;
            // a found pulse on the last timer value still wins over the timeout.
            S_FIND: begin
                if (bus.i_barcode_found) begin
                    state_d = S_DECODE;
                end else if (timer_q == SEARCH_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + SRCH_W'(1);
                end
            end

            S_DECODE: begin
                if (bus.i_dec_done) begin
                    state_d = bus.i_dec_ok ? S_OUT_CFG : S_ERROR;
                end
            end

            S_OUT_CFG: begin
                out_num_d = bus.i_out_num;
                state_d   = (bus.i_out_num == '0) ? S_ERROR : S_LOAD_WGT;
            end

            S_LOAD_WGT: begin
                if (bus.i_in_valid) begin
                    if (wgt_addr_q == WGT_LAST) begin
                        wgt_addr_d = '0;
                        state_d    = S_CONV;
                    end else begin
                        wgt_addr_d = wgt_addr_q + ADDR_W'(1);
                    end
                end
            end

            // out_num_q is non-zero here, so out_num_q - 1 never wraps.
            S_CONV: begin
                if (conv_hs) begin
                    out_cnt_d = out_cnt_q + OUT_W'(1);
                    if (out_cnt_q == out_num_q - OUT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE, S_ERROR: begin
                state_d = state_q;
            end

            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            img_addr_q <= '0;
            wgt_addr_q <= '0;
            timer_q    <= '0;
            out_num_q  <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            img_addr_q <= img_addr_d;
            wgt_addr_q <= wgt_addr_d;
            timer_q    <= timer_d;
            out_num_q  <= out_num_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign bus.o_state_onehot = state_q;
    assign bus.o_in_ready     = (state_q == S_LOAD_IMG) || (state_q == S_LOAD_WGT);
    assign bus.o_img_addr     = img_addr_q;
    assign bus.o_wgt_addr     = wgt_addr_q;
    assign bus.o_cfg_valid    = (state_q == S_OUT_CFG);
    assign bus.o_out_cnt      = out_cnt_q;
    assign bus.o_exe_finish   = (state_q == S_DONE) || (state_q == S_ERROR);
    assign bus.o_error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed flows plus randomized soak runs
// compared each cycle against a phase/count reference model.
module tb_conv_seq_ctrl;

    localparam int IMG_DEPTH    = 16;
    localparam int WGT_DEPTH    = 9;
    localparam int SEARCH_LIMIT = 32;
    localparam int ADDR_W       = 12;
    localparam int OUT_W        = 13;

    localparam int P_IDLE = 0, P_LOAD_IMG = 1, P_FIND = 2, P_DECODE = 3, P_OUT_CFG = 4,
                   P_LOAD_WGT = 5, P_CONV = 6, P_DONE = 7, P_ERROR = 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    conv_seq_ctrl_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

    conv_seq_ctrl #(
        .IMG_DEPTH   (IMG_DEPTH),
        .WGT_DEPTH   (WGT_DEPTH),
        .SEARCH_LIMIT(SEARCH_LIMIT),
        .ADDR_W      (ADDR_W),
        .OUT_W       (OUT_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: current phase plus beat/cycle counts.
    int ph, m_img, m_wgt, m_search, m_num, m_accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  32'(bus.o_state_onehot), 32'(1) << ph);
        check({tag, ".in_rdy"}, 32'(bus.o_in_ready),   32'(ph == P_LOAD_IMG || ph == P_LOAD_WGT));
        check({tag, ".img"},    32'(bus.o_img_addr),   32'(m_img));
        check({tag, ".wgt"},    32'(bus.o_wgt_addr),   32'(m_wgt));
        check({tag, ".cfg"},    32'(bus.o_cfg_valid),  32'(ph == P_OUT_CFG));
        check({tag, ".cnt"},    32'(bus.o_out_cnt),    32'(m_accepted));
        check({tag, ".fin"},    32'(bus.o_exe_finish), 32'(ph == P_DONE || ph == P_ERROR));
        check({tag, ".err"},    32'(bus.o_error),      32'(ph == P_ERROR));
    endtask

    task automatic model_reset();
        ph = P_IDLE;
        m_img = 0; m_wgt = 0; m_search = 0; m_num = 0; m_accepted = 0;
    endtask

    // One clock of the specified behaviour, driven by the inputs currently applied.
    task automatic model_step();
        case (ph)
            P_IDLE: ph = P_LOAD_IMG;
            P_LOAD_IMG: if (bus.i_in_valid) begin
                m_img++;
                if (m_img == IMG_DEPTH) begin m_img = 0; m_search = 0; ph = P_FIND; end
            end
            P_FIND: begin
                m_search++;
                if (bus.i_barcode_found)           ph = P_DECODE;
                else if (m_search == SEARCH_LIMIT) ph = P_ERROR;
            end
            P_DECODE: if (bus.i_dec_done) ph = bus.i_dec_ok ? P_OUT_CFG : P_ERROR;
            P_OUT_CFG: begin
                m_num = int'(bus.i_out_num);
                ph    = (m_num == 0) ? P_ERROR : P_LOAD_WGT;
            end
            P_LOAD_WGT: if (bus.i_in_valid) begin
                m_wgt++;
                if (m_wgt == WGT_DEPTH) begin m_wgt = 0; ph = P_CONV; end
            end
            P_CONV: if (bus.i_conv_valid && bus.i_out_ready) begin
                m_accepted++;
                if (m_accepted == m_num) ph = P_DONE;
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.i_in_valid      = 1'b0;
        bus.i_barcode_found = 1'b0;
        bus.i_dec_done      = 1'b0;
        bus.i_dec_ok        = 1'b0;
        bus.i_out_num       = '0;
        bus.i_conv_valid    = 1'b0;
        bus.i_out_ready     = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        model_reset();
        check_all({tag, ".rst"});
        check({tag, ".rst_onehot"}, 32'(bus.o_state_onehot), 32'h001);
        i_rst_n = 1'b1;
    endtask

    // mode 0: every cycle valid; 1: every third cycle idle; 2: random gaps.
    task automatic load_image(input string tag, input int mode);
        int c = 0;
        int hit_last = 0;
        while ((ph == P_IDLE || ph == P_LOAD_IMG) && c < 200) begin
            case (mode)
                0:       bus.i_in_valid = 1'b1;
                1:       bus.i_in_valid = (c % 3) != 2;
                default: bus.i_in_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (bus.o_img_addr == ADDR_W'(IMG_DEPTH - 1)) hit_last = 1;
            cycle({tag, ".img"});
            c++;
        end
        idle_inputs();
        check({tag, ".img_reached_last"}, 32'(hit_last), 32'd1);
        check({tag, ".img_to_find"}, 32'(bus.o_state_onehot), 32'h004);
        check({tag, ".img_wrapped"}, 32'(bus.o_img_addr), 32'd0);
    endtask

    // Drive found on FIND cycle index found_at (-1: never); returns DUT cycles spent in FIND.
    task automatic search(input string tag, input int found_at, output int find_cycles);
        int k = 0;
        find_cycles = 0;
        while (ph == P_FIND && k < 100) begin
            bus.i_barcode_found = (k == found_at);
            bus.i_in_valid      = 1'b1;
            bus.i_dec_done      = 1'($urandom_range(0, 1));
            if (bus.o_state_onehot == 9'h004) find_cycles++;
            cycle({tag, ".find"});
            k++;
        end
        idle_inputs();
    endtask

    task automatic decode(input string tag, input int wait_cycles, input logic ok);
        for (int i = 0; i < wait_cycles; i++) begin
            bus.i_in_valid   = 1'b1;
            bus.i_conv_valid = 1'b1;
            bus.i_out_ready  = 1'b1;
            cycle({tag, ".dec_wait"});
        end
        idle_inputs();
        bus.i_dec_done = 1'b1;
        bus.i_dec_ok   = ok;
        cycle({tag, ".dec"});
        idle_inputs();
    endtask

    task automatic out_cfg(input string tag, input int num);
        bus.i_out_num = OUT_W'(num);
        cycle({tag, ".cfg"});
        idle_inputs();
    endtask

    // Random-gap weight load; stops early once stop_at beats are accepted (-1: full load).
    task automatic load_weights(input string tag, input int stop_at);
        int c = 0;
        while (ph == P_LOAD_WGT && c < 200 && !(stop_at >= 0 && m_wgt == stop_at)) begin
            bus.i_in_valid = ($urandom_range(0, 2) != 0);
            cycle({tag, ".wgt"});
            c++;
        end
        idle_inputs();
    endtask

    task automatic conv_random(input string tag);
        int c = 0;
        while (ph == P_CONV && c < 200) begin
            bus.i_in_valid   = 1'b1;
            bus.i_conv_valid = 1'($urandom_range(0, 1));
            bus.i_out_ready  = 1'($urandom_range(0, 1));
            cycle({tag, ".conv"});
            c++;
        end
        idle_inputs();
    endtask

    task automatic terminal_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_in_valid      = 1'($urandom_range(0, 1));
            bus.i_barcode_found = 1'($urandom_range(0, 1));
            bus.i_dec_done      = 1'($urandom_range(0, 1));
            bus.i_dec_ok        = 1'($urandom_range(0, 1));
            bus.i_out_num       = OUT_W'($urandom_range(0, 7));
            bus.i_conv_valid    = 1'($urandom_range(0, 1));
            bus.i_out_ready     = 1'($urandom_range(0, 1));
            cycle({tag, ".hold"});
        end
        idle_inputs();
    endtask

    // Fully random stimulus on every input, every cycle, until a terminal state.
    task automatic soak(input string tag);
        int c = 0;
        do_reset(tag);
        while (ph != P_DONE && ph != P_ERROR && c < 600) begin
            bus.i_in_valid      = ($urandom_range(0, 3) != 0);
            bus.i_barcode_found = ($urandom_range(0, 30) == 0);
            bus.i_dec_done      = ($urandom_range(0, 2) == 0);
            bus.i_dec_ok        = ($urandom_range(0, 4) != 0);
            bus.i_out_num       = OUT_W'($urandom_range(0, 6));
            bus.i_conv_valid    = 1'($urandom_range(0, 1));
            bus.i_out_ready     = 1'($urandom_range(0, 1));
            cycle(tag);
            c++;
        end
        terminal_hold(tag, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        logic [OUT_W-1:0] exp_cnt [5];
        logic             rdy_seq [5];

        // Nominal flow, with spurious in_valid during IDLE, FIND, DECODE and CONV.
        do_reset("nom");
        load_image("nom", 1);
        search("nom", 4, fc);
        check("nom.find_to_decode", 32'(bus.o_state_onehot), 32'h008);
        decode("nom", 2, 1'b1);
        check("nom.cfg_valid", 32'(bus.o_cfg_valid), 32'd1);
        out_cfg("nom", 4);
        check("nom.cfg_one_cycle", 32'(bus.o_cfg_valid), 32'd0);
        load_weights("nom", -1);
        check("nom.wgt_wrapped", 32'(bus.o_wgt_addr), 32'd0);
        conv_random("nom");
        check("nom.done_onehot", 32'(bus.o_state_onehot), 32'h080);
        check("nom.out_cnt",     32'(bus.o_out_cnt),      32'd4);
        check("nom.finish",      32'(bus.o_exe_finish),   32'd1);
        check("nom.no_error",    32'(bus.o_error),        32'd0);
        terminal_hold("nom", 6);
        check("nom.out_cnt_hold", 32'(bus.o_out_cnt), 32'd4);

        // Search timeout: found never asserted.
        do_reset("tmo");
        load_image("tmo", 0);
        search("tmo", -1, fc);
        check("tmo.find_cycles", 32'(fc), 32'(SEARCH_LIMIT));
        check("tmo.error_onehot", 32'(bus.o_state_onehot), 32'h100);
        check("tmo.error", 32'(bus.o_error), 32'd1);
        terminal_hold("tmo", 4);

        // Found on the final search cycle beats the timeout.
        do_reset("race");
        load_image("race", 2);
        search("race", SEARCH_LIMIT - 1, fc);
        check("race.find_cycles", 32'(fc), 32'(SEARCH_LIMIT));
        check("race.decode_onehot", 32'(bus.o_state_onehot), 32'h008);

        // Decode failure.
        do_reset("dfail");
        load_image("dfail", 0);
        search("dfail", 0, fc);
        decode("dfail", 3, 1'b0);
        check("dfail.error_onehot", 32'(bus.o_state_onehot), 32'h100);

        // Zero output count: one OUT_CFG cycle, then ERROR.
        do_reset("zero");
        load_image("zero", 0);
        search("zero", 2, fc);
        decode("zero", 0, 1'b1);
        check("zero.cfg_onehot", 32'(bus.o_state_onehot), 32'h010);
        out_cfg("zero", 0);
        check("zero.error_onehot", 32'(bus.o_state_onehot), 32'h100);
        check("zero.finish", 32'(bus.o_exe_finish), 32'd1);

        // Backpressure: out_num=3, valid held, ready 1,0,0,1,1.
        do_reset("bp");
        load_image("bp", 0);
        search("bp", 1, fc);
        decode("bp", 1, 1'b1);
        out_cfg("bp", 3);
        load_weights("bp", -1);
        check("bp.conv_onehot", 32'(bus.o_state_onehot), 32'h040);
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_cnt = '{13'd1, 13'd1, 13'd1, 13'd2, 13'd3};
        for (int i = 0; i < 5; i++) begin
            bus.i_conv_valid = 1'b1;
            bus.i_out_ready  = rdy_seq[i];
            check("bp.not_done_yet", 32'(bus.o_state_onehot), 32'h040);
            cycle("bp.step");
            check("bp.cnt_step", 32'(bus.o_out_cnt), 32'(exp_cnt[i]));
        end
        idle_inputs();
        check("bp.done_onehot", 32'(bus.o_state_onehot), 32'h080);

        // Asynchronous reset in the middle of the weight load.
        do_reset("mrst");
        load_image("mrst", 0);
        search("mrst", 3, fc);
        decode("mrst", 0, 1'b1);
        out_cfg("mrst", 5);
        load_weights("mrst", 5);
        check("mrst.wgt_at_5", 32'(bus.o_wgt_addr), 32'd5);
        bus.i_in_valid = 1'b1;
        #3 i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mrst.async");
        idle_inputs();
        @(negedge i_clk);
        check_all("mrst.held");
        i_rst_n = 1'b1;
        bus.i_in_valid = 1'b1;
        cycle("mrst.idle");
        check("mrst.load_img", 32'(bus.o_state_onehot), 32'h002);
        check("mrst.img_zero", 32'(bus.o_img_addr), 32'd0);
        cycle("mrst.first_beat");
        idle_inputs();

        // Randomized full-flow soak runs.
        for (int r = 0; r < 6; r++) soak("soak");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Parametrised top-level sequencer for the barcode-configured convolution engine.
- Steps through: image load → barcode search → decode → config output → weight load → convolution → finish/error.
- Unlike the previous fixed-flag controller, it owns the image, weight and output beat counters and a barcode-search timeout.
- Ends in a sticky terminal state with explicit error reporting.

Parameters:
IMG_DEPTH, 4096, pixels per image load burst (>=2)
WGT_DEPTH, 9, weight words per weight load burst (>=2)
SEARCH_LIMIT, 4096, max cycles in barcode search before timeout (>=2)
ADDR_W, 12, width of address/count outputs; must satisfy 2^ADDR_W >= max(IMG_DEPTH, WGT_DEPTH)
OUT_W, 13, width of output-count config

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_in_valid  in  1  input beat valid (image or weight stream)
i_barcode_found  in  1  search datapath located barcode
i_dec_done  in  1  decoder finished (single-cycle pulse)
i_dec_ok  in  1  decode result legal; sampled only with i_dec_done
i_out_num  in  OUT_W  number of conv outputs from decoded config; sampled in S_OUT_CFG
i_conv_valid  in  1  conv datapath has an output beat
i_out_ready  in  1  downstream accepts output beat
o_in_ready  out  1  high in S_LOAD_IMG and S_LOAD_WGT only
o_img_addr  out  ADDR_W  image write address
o_wgt_addr  out  ADDR_W  weight write address
o_state_onehot  out  9  one-hot state: bit0 IDLE, 1 LOAD_IMG, 2 FIND, 3 DECODE, 4 OUT_CFG, 5 LOAD_WGT, 6 CONV, 7 DONE, 8 ERROR
o_cfg_valid  out  1  high for the single S_OUT_CFG cycle
o_out_cnt  out  OUT_W  accepted output beats in S_CONV
o_exe_finish  out  1  high in DONE or ERROR
o_error  out  1  high in ERROR

Behaviour:
- Reset:
  - Async assert forces state IDLE; all counters and latched out_num go to 0.
  - Outputs under reset: o_state_onehot=9'h001, all other outputs 0.
  - Reset mid-operation aborts immediately with no residual state.
- Registered outputs: all outputs are decoded from registers only; no combinational input-to-output path.
- IDLE: always exactly one cycle, then LOAD_IMG. i_in_valid is ignored in IDLE.
- LOAD_IMG:
  - Each cycle with i_in_valid=1 is one beat at address o_img_addr; o_img_addr then increments.
  - On the beat at o_img_addr==IMG_DEPTH-1: next state FIND, o_img_addr wraps to 0.
  - Gaps in i_in_valid are allowed and stall the counter.
- FIND:
  - Search timer starts at 0 on entry and increments every cycle.
  - i_barcode_found=1 → DECODE.
  - Otherwise, when timer==SEARCH_LIMIT-1 → ERROR.
  - If found and timeout occur in the same cycle, found wins.
- DECODE:
  - Waits indefinitely for i_dec_done.
  - i_dec_done && i_dec_ok → OUT_CFG; i_dec_done && !i_dec_ok → ERROR.
- OUT_CFG:
  - One cycle; o_cfg_valid=1; i_out_num is latched.
  - Latched value 0 → ERROR; else → LOAD_WGT.
- LOAD_WGT:
  - Same beat rules as LOAD_IMG, using o_wgt_addr and WGT_DEPTH.
  - Last beat → CONV, o_wgt_addr wraps to 0.
- CONV:
  - A handshake is i_conv_valid && i_out_ready; each handshake increments o_out_cnt.
  - Handshake when o_out_cnt==latched_out_num-1 → DONE.
  - o_out_cnt holds its final value (latched_out_num) in DONE.
  - i_conv_valid without i_out_ready does not count.
- DONE / ERROR:
  - Terminal; only reset leaves either state.
  - o_exe_finish=1 in both; o_error=1 in ERROR only.
  - All inputs are ignored.
- Out-of-state inputs: i_in_valid outside the load states, and found/dec/conv inputs outside their own state, never move counters or state.
- Width rules:
  - Counters compare exactly against DEPTH-1; no overflow is possible.
  - o_out_cnt is OUT_W bits and compares against the full latched OUT_W value.

Test Plan:
Use IMG_DEPTH=16, WGT_DEPTH=9, SEARCH_LIMIT=32.
- Nominal flow:
  - Stimulus: reset; 16 image beats with every 3rd cycle idle; found at cycle 5 of FIND; dec_done+ok 2 cycles later; i_out_num=4; 9 weight beats; 4 handshakes.
  - Required response: o_img_addr runs 0..15 then wraps to 0; o_cfg_valid high for exactly 1 cycle; o_state_onehot reaches 9'h080; o_out_cnt=4; o_exe_finish=1, o_error=0.
- Search timeout:
  - Stimulus: i_barcode_found never asserted.
  - Required response: exactly 32 cycles in FIND, then ERROR (9'h100), o_error=1.
  - Repeat with found and timeout asserted in the same cycle → DECODE.
- Decode fail and zero config:
  - Stimulus: dec_done with ok=0.
  - Required response: ERROR.
  - Second run: ok=1 with i_out_num=0 → OUT_CFG for 1 cycle, then ERROR.
- Backpressure:
  - Stimulus: in CONV with out_num=3, hold i_conv_valid=1 and toggle i_out_ready 1,0,0,1,1.
  - Required response: o_out_cnt steps 1,1,1,2,3; DONE entered after the 5th cycle.
- Spurious inputs:
  - Stimulus: i_in_valid=1 during IDLE, FIND, DECODE and CONV.
  - Required response: o_img_addr and o_wgt_addr unchanged; o_in_ready=0 in those states.
- Reset mid-operation:
  - Stimulus: assert i_rst_n=0 asynchronously at weight beat 5.
  - Required response: outputs clear immediately; after release, IDLE for 1 cycle, then LOAD_IMG with o_img_addr=0.
